// File: rtl/echo_delay.sv
// echo_delay: feedback echo effect for the tiny-synth audio path.
//
// Each accepted sample is mixed 50/50 with a sample read from a circular
// delay buffer. The buffer is written back with the input plus an
// attenuated copy of the delayed sample, so echoes repeat and decay.
// One read/mix/write sequence runs per sample through a single-port RAM
// with a one-cycle synchronous read. The RAM is cleared after every reset.
//
// Ports:
//   clk           system clock (only clock)
//   rst           synchronous active-high reset
//   din_valid     one-cycle strobe, din holds a new sample
//   din           signed input sample
//   delay_length  echo delay in samples (0 means a full buffer length)
//   feedback      unsigned Q0.8 feedback gain
//   dout          signed mixed output sample, held between strobes
//   dout_valid    one-cycle strobe, dout updated
//   busy          high whenever a din_valid would not be accepted
//   overrun       sticky flag: a din_valid was dropped (cleared by rst)
module echo_delay #(
  parameter int SAMPLE_BITS              = 12,
  parameter int DELAY_BUFFER_LENGTH_BITS = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                din_valid,
  input  logic signed [SAMPLE_BITS-1:0]       din,
  input  logic [DELAY_BUFFER_LENGTH_BITS-1:0] delay_length,
  input  logic [7:0]                          feedback,
  output logic signed [SAMPLE_BITS-1:0]       dout,
  output logic                                dout_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int SB = SAMPLE_BITS;
  localparam int AB = DELAY_BUFFER_LENGTH_BITS;
  localparam int L  = 1 << AB;

  // Saturation limits at the width of the feedback sum.
  localparam logic signed [SB+8:0] SAT_MAX = (SB+9)'(2**(SB-1) - 1);
  localparam logic signed [SB+8:0] SAT_MIN = (SB+9)'(-(2**(SB-1)));

  typedef enum logic [2:0] {CLEAR, IDLE, READ, MIX, WRITE} state_t;

  state_t state, state_next;

  logic [AB-1:0]        clr_cnt;
  logic [AB-1:0]        wptr;

  // Operands latched in the IDLE acceptance cycle.
  logic signed [SB-1:0] din_r;
  logic [AB-1:0]        delay_r;
  logic [7:0]           feedback_r;

  // RAM port.
  logic                 ram_we;
  logic [AB-1:0]        ram_addr;
  logic signed [SB-1:0] ram_wdata;
  logic signed [SB-1:0] rdata;
  logic signed [SB-1:0] mem [L];

  // Mix datapath.
  logic signed [SB:0]   mix_sum;
  logic signed [SB+8:0] prod;
  logic signed [SB+8:0] wsum;
  logic signed [SB-1:0] dout_next;
  logic signed [SB-1:0] wdata_next;
  logic signed [SB-1:0] wdata;

  assign busy = (state != IDLE);

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (&clr_cnt) state_next = IDLE;
      IDLE:  if (din_valid) state_next = READ;
      READ:  state_next = MIX;
      MIX:   state_next = WRITE;
      WRITE: state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // RAM address/write mux: one access per cycle.
  // NOTE: every always_comb output gets a default first, otherwise any
  // path that skips an assignment infers a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = wptr - delay_r;   // wraps modulo L by width
    ram_wdata = wdata;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
      end
      WRITE: begin
        ram_we   = 1'b1;
        ram_addr = wptr;
      end
      default: ;
    endcase
  end

  // Single-port RAM, synchronous read. Writes are blocked while rst is
  // high so an aborted sample never reaches the buffer.
  // NOTE: the memory array has no reset; it is cleared by the CLEAR
  // state instead, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[ram_addr] <= ram_wdata;
    rdata <= mem[ram_addr];
  end

  // Mix: average of input and delayed sample (cannot overflow at SB+1),
  // and saturated input-plus-attenuated-echo for the write-back word.
  always_comb begin
    mix_sum   = (SB+1)'(din_r) + (SB+1)'(rdata);
    dout_next = SB'(mix_sum >>> 1);
    prod      = (SB+9)'(rdata) * (SB+9)'($signed({1'b0, feedback_r}));
    wsum      = (SB+9)'(din_r) + (prod >>> 8);
    if (wsum > SAT_MAX)      wdata_next = {1'b0, {(SB-1){1'b1}}};
    else if (wsum < SAT_MIN) wdata_next = {1'b1, {(SB-1){1'b0}}};
    else                     wdata_next = SB'(wsum);
  end

  // Control state and outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      wptr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      dout_valid <= 1'b0;
      if (state == CLEAR) clr_cnt <= clr_cnt + AB'(1);
      if (state == MIX) begin
        dout       <= dout_next;
        dout_valid <= 1'b1;
      end
      if (state == WRITE) wptr <= wptr + AB'(1);
      if (din_valid && state != IDLE) overrun <= 1'b1;
    end
  end

  // Datapath registers: no reset needed, always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && din_valid) begin
      din_r      <= din;
      delay_r    <= delay_length;
      feedback_r <= feedback;
    end
    if (state == MIX) wdata <= wdata_next;
  end

endmodule

// File: tb/tb_echo_delay.sv
// Directed testbench for echo_delay with a 16-word buffer.
module tb_echo_delay;

  localparam int SB = 12;
  localparam int AB = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 din_valid = 1'b0;
  logic signed [SB-1:0] din = '0;
  logic [AB-1:0]        delay_length = '0;
  logic [7:0]           feedback = '0;
  logic signed [SB-1:0] dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  int exp_imp[9]   = '{500, 0, 0, 0, 500, 0, 0, 0, 0};
  int exp_decay[13] = '{500, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
  int din_pos[9]   = '{2047, 0, 0, 0, 2047, 0, 0, 0, 0};
  int exp_pos[9]   = '{1023, 0, 0, 0, 2047, 0, 0, 0, 1023};
  int din_neg[9]   = '{-2048, 0, 0, 0, -2048, 0, 0, 0, 0};
  int exp_neg[9]   = '{-1024, 0, 0, 0, -2048, 0, 0, 0, -1024};

  echo_delay #(
    .SAMPLE_BITS(SB),
    .DELAY_BUFFER_LENGTH_BITS(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_valid(din_valid),
    .din(din),
    .delay_length(delay_length),
    .feedback(feedback),
    .dout(dout),
    .dout_valid(dout_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge in the first CLEAR cycle; counts busy cycles.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_clear_len"}, n, 16);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check({tag, "_rst_dout"}, dout, 0);
    check({tag, "_rst_dv"}, dout_valid, 0);
    check({tag, "_rst_ovr"}, overrun, 0);
    check({tag, "_rst_busy"}, busy, 1);
    wait_clear(tag);
  endtask

  // One sample in an 8-clock slot; checks latency, strobe count, value and
  // the busy window (high T+1..T+3, low afterwards).
  task automatic send_sample(input string tag, input int d, input int dly,
                             input int fb, input int exp);
    int n = 0, lat = 0, got = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    din_valid = 1'b1;
    din = SB'(d);
    delay_length = AB'(dly);
    feedback = 8'(fb);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      if (dout_valid) begin
        n++;
        lat = i;
        got = dout;
      end
      if (busy != (i <= 3)) busy_ok = 1'b0;
    end
    check({tag, "_nvalid"}, n, 1);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_dout"}, got, exp);
    check({tag, "_busy"}, int'(busy_ok), 1);
  endtask

  initial begin
    int n;
    int got;
    bit seen;

    repeat (3) @(negedge clk);

    // Reset/clear: every zero-delay read returns a cleared word.
    do_reset("clr");
    for (int i = 0; i < 16; i++)
      send_sample($sformatf("clr[%0d]", i), 100, 0, 0, 50);

    // Impulse without feedback.
    do_reset("imp");
    for (int i = 0; i < 9; i++)
      send_sample($sformatf("imp[%0d]", i), (i == 0) ? 1000 : 0, 4, 0, exp_imp[i]);

    // Decaying echoes at half gain.
    do_reset("dec");
    for (int i = 0; i < 13; i++)
      send_sample($sformatf("dec[%0d]", i), (i == 0) ? 1000 : 0, 4, 128, exp_decay[i]);

    // Positive and negative saturation of the stored word.
    do_reset("satp");
    for (int i = 0; i < 9; i++)
      send_sample($sformatf("satp[%0d]", i), din_pos[i], 4, 255, exp_pos[i]);
    do_reset("satn");
    for (int i = 0; i < 9; i++)
      send_sample($sformatf("satn[%0d]", i), din_neg[i], 4, 255, exp_neg[i]);

    // Overrun: second strobe lands in MIX and is dropped.
    do_reset("ovr");
    n = 0;
    got = 0;
    @(negedge clk);
    din_valid = 1'b1; din = 12'sd600; delay_length = 4'd4; feedback = 8'd0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      if (i == 2) begin din_valid = 1'b1; din = -12'sd600; end
      if (i == 3) din_valid = 1'b0;
      if (dout_valid) begin n++; got = dout; end
    end
    check("ovr_nvalid", n, 1);
    check("ovr_dout", got, 300);
    check("ovr_flag", overrun, 1);
    send_sample("ovr_next", 0, 4, 0, 0);
    check("ovr_hold", overrun, 1);

    // Zero delay means a full-buffer echo across the pointer wrap.
    do_reset("wrap");
    for (int i = 0; i < 17; i++)
      send_sample($sformatf("wrap[%0d]", i), (i == 0) ? 1000 : 0, 0, 0,
                  (i == 0 || i == 16) ? 500 : 0);

    // Reset during MIX aborts the sample and re-clears the buffer.
    do_reset("mid");
    send_sample("mid_pre", 1000, 0, 0, 500);
    seen = 1'b0;
    @(negedge clk);
    din_valid = 1'b1; din = 12'sd777; delay_length = 4'd0; feedback = 8'd0;
    @(negedge clk); din_valid = 1'b0; seen |= dout_valid;
    @(negedge clk); seen |= dout_valid; rst = 1'b1;
    @(negedge clk); seen |= dout_valid; rst = 1'b0;
    check("mid_no_valid", int'(seen), 0);
    check("mid_wptr", int'(dut.wptr), 0);
    check("mid_ovr", overrun, 0);
    wait_clear("mid");
    for (int i = 0; i < 16; i++)
      send_sample($sformatf("mid_post[%0d]", i), 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
